// File: rtl/pktarbiter_if.sv
// AXIN bundle between the per-source broadcasters, the arbiter and one TX port.
// slave = arbiter view, master = the environment driving sources and sinking output.
interface pktarbiter_if #(
  parameter int NIN = 4,
  parameter int DW  = 64,
  parameter int BW  = $clog2(DW)
);
  logic [NIN-1:0]    S_VALID;
  logic [NIN-1:0]    S_READY;
  logic [NIN*DW-1:0] S_DATA;
  logic [NIN*BW-1:0] S_BYTES;
  logic [NIN-1:0]    S_LAST;
  logic [NIN-1:0]    S_ABORT;

  logic              M_VALID;
  logic              M_READY;
  logic [DW-1:0]     M_DATA;
  logic [BW-1:0]     M_BYTES;
  logic              M_LAST;
  logic              M_ABORT;

  modport slave (
    input  S_VALID, S_DATA, S_BYTES, S_LAST, S_ABORT, M_READY,
    output S_READY, M_VALID, M_DATA, M_BYTES, M_LAST, M_ABORT
  );

  modport master (
    output S_VALID, S_DATA, S_BYTES, S_LAST, S_ABORT, M_READY,
    input  S_READY, M_VALID, M_DATA, M_BYTES, M_LAST, M_ABORT
  );
endinterface

// File: rtl/pktarbiter.sv
// Per-egress packet arbiter: round-robin over NIN AXIN sources, whole packets only,
// with an abort beat synthesised when the granted source is disabled mid-packet.
module pktarbiter #(
  parameter int NIN = 4,
  parameter int DW  = 64,
  parameter int BW  = $clog2(DW)
) (
  input  logic           i_clk,
  input  logic           i_reset,
  input  logic [NIN-1:0] i_cfg_active,
  pktarbiter_if.slave    bus,
  output logic [NIN-1:0] o_grant
);
  localparam int IW = (NIN > 1) ? $clog2(NIN) : 1;

  typedef enum logic [1:0] {ST_IDLE, ST_ACTIVE, ST_FLUSH} state_t;

  state_t          state_q, state_d;
  logic [NIN-1:0]  grant_q, grant_d;
  logic [IW-1:0]   rr_q, rr_d;
  logic            midpkt_q, midpkt_d;
  logic [DW-1:0]   data_q, data_d;

  logic [IW-1:0]   gidx, gidx_nxt, pick_idx;
  logic            pick_found;
  logic [NIN-1:0]  req, s_ready;
  logic            g_valid, g_last, g_abort, g_active;
  logic [DW-1:0]   g_data;
  logic [BW-1:0]   g_bytes;
  logic            m_valid, m_last, m_abort;
  logic [DW-1:0]   m_data;
  logic [BW-1:0]   m_bytes;

  assign req = bus.S_VALID & i_cfg_active;

  always_comb begin : grant_index
    gidx = '0;
    for (int unsigned i = 0; i < NIN; i++) begin
      if (grant_q[i]) gidx = IW'(i);
    end
  end

  assign gidx_nxt = (int'(gidx) == NIN - 1) ? '0 : gidx + IW'(1);

  // First requester at or above rr, wrapping modulo NIN.
  always_comb begin : rr_scan
    pick_found = 1'b0;
    pick_idx   = '0;
    for (int unsigned k = 0; k < NIN; k++) begin
      if (!pick_found && req[IW'((32'(rr_q) + k) % NIN)]) begin
        pick_found = 1'b1;
        pick_idx   = IW'((32'(rr_q) + k) % NIN);
      end
    end
  end

  always_comb begin : src_mux
    g_valid  = bus.S_VALID[gidx];
    g_last   = bus.S_LAST[gidx];
    g_abort  = bus.S_ABORT[gidx];
    g_active = i_cfg_active[gidx];
    g_data   = bus.S_DATA[int'(gidx) * DW +: DW];
    g_bytes  = bus.S_BYTES[int'(gidx) * BW +: BW];
  end

  always_comb begin : fsm_comb
    state_d  = state_q;
    grant_d  = grant_q;
    rr_d     = rr_q;
    midpkt_d = midpkt_q;
    data_d   = data_q;
    m_valid  = 1'b0;
    m_data   = data_q;
    m_bytes  = '0;
    m_last   = 1'b0;
    m_abort  = 1'b0;
    s_ready  = ~i_cfg_active;

    unique case (state_q)
      ST_IDLE: begin
        if (pick_found) begin
          grant_d  = NIN'(1) << pick_idx;
          midpkt_d = 1'b0;
          state_d  = ST_ACTIVE;
        end
      end

      ST_ACTIVE: begin
        m_data  = g_data;
        m_bytes = g_bytes;
        m_last  = g_last;
        m_abort = g_abort;
        // A disable outranks any beat the source presents in the same cycle.
        if (!g_active) begin
          if (midpkt_q) begin
            state_d = ST_FLUSH;
          end else begin
            state_d = ST_IDLE;
            grant_d = '0;
            rr_d    = gidx_nxt;
          end
        end else begin
          m_valid       = g_valid;
          s_ready[gidx] = bus.M_READY;
          if (g_valid && bus.M_READY) begin
            midpkt_d = 1'b1;
            data_d   = g_data;
            if (g_last || g_abort) begin
              state_d = ST_IDLE;
              grant_d = '0;
              rr_d    = gidx_nxt;
            end
          end
        end
      end

      ST_FLUSH: begin
        m_valid = 1'b1;
        m_abort = 1'b1;
        if (bus.M_READY) begin
          state_d = ST_IDLE;
          grant_d = '0;
          rr_d    = gidx_nxt;
        end
      end

      default: begin
        state_d = ST_IDLE;
        grant_d = '0;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q  <= ST_IDLE;
      grant_q  <= '0;
      rr_q     <= '0;
      midpkt_q <= 1'b0;
      data_q   <= '0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      rr_q     <= rr_d;
      midpkt_q <= midpkt_d;
      data_q   <= data_d;
    end
  end

  assign bus.S_READY = s_ready;
  assign bus.M_VALID = m_valid;
  assign bus.M_DATA  = m_data;
  assign bus.M_BYTES = m_bytes;
  assign bus.M_LAST  = m_last;
  assign bus.M_ABORT = m_abort;
  assign o_grant     = grant_q;

endmodule

// File: tb/tb_pktarbiter.sv
// Self-checking bench for pktarbiter: grant table, directed corner sequences,
// then randomized traffic against a cycle-level behavioural model.
module tb_pktarbiter;
  localparam int NIN = 4;
  localparam int DW  = 64;
  localparam int BW  = $clog2(DW);

  logic           clk = 1'b0;
  logic           rst;
  logic [NIN-1:0] act;
  logic [NIN-1:0] grant;

  pktarbiter_if #(.NIN(NIN), .DW(DW), .BW(BW)) bus ();

  pktarbiter #(.NIN(NIN), .DW(DW), .BW(BW)) dut (
    .i_clk       (clk),
    .i_reset     (rst),
    .i_cfg_active(act),
    .bus         (bus),
    .o_grant     (grant)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct packed {
    logic [NIN-1:0] req;
    logic [NIN-1:0] exp_grant;
  } vec_t;

  // random-phase source state and model state
  int rem [NIN];
  int owner, nacc, rr_m;
  bit flushing, found;
  logic [NIN-1:0] e_sready, e_grant, acc;
  logic           e_mvalid, e_last, e_abort;
  logic [DW-1:0]  e_data;
  logic [BW-1:0]  e_bytes;

  task automatic chk_vec(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got %0h, expected %0h", name, $time, got, exp);
    end
  endtask

  task automatic chk_bit(input string name, input logic got, input logic exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got %b, expected %b", name, $time, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_src(input int s, input logic v, input logic [DW-1:0] d,
                         input logic [BW-1:0] b, input logic l, input logic a);
    bus.S_VALID[s]           = v;
    bus.S_DATA[s*DW +: DW]   = d;
    bus.S_BYTES[s*BW +: BW]  = b;
    bus.S_LAST[s]            = l;
    bus.S_ABORT[s]           = a;
  endtask

  task automatic clear_srcs();
    bus.S_VALID = '0;
    bus.S_DATA  = '0;
    bus.S_BYTES = '0;
    bus.S_LAST  = '0;
    bus.S_ABORT = '0;
  endtask

  task automatic idle_chk(input string name);
    #1;
    chk_vec({name, "_grant"}, 64'(grant), 64'(0));
    chk_bit({name, "_mvalid"}, bus.M_VALID, 1'b0);
  endtask

  // Present one beat on source s, expect it forwarded unchanged, then clock it through.
  task automatic pass_beat(input string name, input int s, input logic [DW-1:0] d,
                           input logic [BW-1:0] b, input logic l, input logic a);
    set_src(s, 1'b1, d, b, l, a);
    #1;
    chk_vec({name, "_grant"}, 64'(grant), 64'(NIN'(1) << s));
    chk_bit({name, "_mvalid"}, bus.M_VALID, 1'b1);
    chk_vec({name, "_mdata"}, bus.M_DATA, d);
    chk_vec({name, "_mbytes"}, 64'(bus.M_BYTES), 64'(b));
    chk_bit({name, "_mlast"}, bus.M_LAST, l);
    chk_bit({name, "_mabort"}, bus.M_ABORT, a);
    chk_bit({name, "_sready_g"}, bus.S_READY[s], bus.M_READY);
    tick();
  endtask

  function automatic logic [DW-1:0] vdata(input int v, input int s);
    return 64'hC0DE_0000_0000_0000 | 64'(v * 16 + s);
  endfunction

  function automatic int onehot_idx(input logic [NIN-1:0] oh);
    int r = 0;
    for (int i = 0; i < NIN; i++) if (oh[i]) r = i;
    return r;
  endfunction

  task automatic new_beat(input int s);
    if (rem[s] == 0) rem[s] = int'($urandom_range(1, 5));
    set_src(s, 1'b1, {$urandom, $urandom}, BW'($urandom), rem[s] == 1,
            $urandom_range(0, 15) == 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vec_t tbl [8];
    int   g, k;

    // ---------------- reset values ----------------
    rst = 1'b1;
    act = '1;
    clear_srcs();
    bus.M_READY = 1'b1;
    tick();
    tick();
    #1;
    chk_bit("rst_mvalid", bus.M_VALID, 1'b0);
    chk_vec("rst_grant", 64'(grant), 64'(0));
    chk_vec("rst_sready", 64'(bus.S_READY), 64'(0));
    chk_vec("rst_mdata", bus.M_DATA, 64'(0));
    chk_vec("rst_mbytes", 64'(bus.M_BYTES), 64'(0));
    chk_bit("rst_mlast", bus.M_LAST, 1'b0);
    chk_bit("rst_mabort", bus.M_ABORT, 1'b0);
    rst = 1'b0;
    tick();

    // ---------------- round-robin grant table (rr starts at 0) ----------------
    tbl[0] = '{req: 4'b1111, exp_grant: 4'b0001};
    tbl[1] = '{req: 4'b0101, exp_grant: 4'b0100};
    tbl[2] = '{req: 4'b0011, exp_grant: 4'b0001};
    tbl[3] = '{req: 4'b1000, exp_grant: 4'b1000};
    tbl[4] = '{req: 4'b0110, exp_grant: 4'b0010};
    tbl[5] = '{req: 4'b0001, exp_grant: 4'b0001};
    tbl[6] = '{req: 4'b1110, exp_grant: 4'b0010};
    tbl[7] = '{req: 4'b1011, exp_grant: 4'b1000};
    for (int v = 0; v < 8; v++) begin
      for (int s = 0; s < NIN; s++) set_src(s, tbl[v].req[s], vdata(v, s), '0, 1'b1, 1'b0);
      idle_chk("tbl_idle");
      tick();
      #1;
      g = onehot_idx(tbl[v].exp_grant);
      chk_vec("tbl_grant", 64'(grant), 64'(tbl[v].exp_grant));
      chk_bit("tbl_mvalid", bus.M_VALID, 1'b1);
      chk_vec("tbl_mdata", bus.M_DATA, vdata(v, g));
      chk_bit("tbl_mlast", bus.M_LAST, 1'b1);
      chk_vec("tbl_sready", 64'(bus.S_READY), 64'(tbl[v].exp_grant));
      tick();
      clear_srcs();
    end

    // ---------------- continuous requests, 2-beat packets: order 0,1,2,3,0 ----------------
    for (int p = 0; p < 5; p++) begin
      for (int s = 0; s < NIN; s++) set_src(s, 1'b1, vdata(20 + p, s), '0, 1'b0, 1'b0);
      idle_chk("rr_bubble");
      tick();
      pass_beat("rr_b0", p % NIN, vdata(20 + p, p % NIN), '0, 1'b0, 1'b0);
      pass_beat("rr_b1", p % NIN, vdata(40 + p, p % NIN), '0, 1'b1, 1'b0);
    end
    clear_srcs();

    // ---------------- single packet from source 2 (rr = 1) ----------------
    set_src(2, 1'b1, 64'h1111_2222_3333_4444, '0, 1'b0, 1'b0);
    idle_chk("single_req");
    tick();
    pass_beat("single_b0", 2, 64'h1111_2222_3333_4444, 6'd0, 1'b0, 1'b0);
    pass_beat("single_b1", 2, 64'h5555_6666_7777_8888, 6'd0, 1'b0, 1'b0);
    pass_beat("single_b2", 2, 64'h9999_AAAA_BBBB_CCCC, 6'd5, 1'b1, 1'b0);
    clear_srcs();
    idle_chk("single_end");

    // ---------------- backpressure, 5 beats from source 1 (rr = 3) ----------------
    k = 0;
    set_src(1, 1'b1, vdata(60, 0), '0, 1'b0, 1'b0);
    idle_chk("bp_req");
    tick();
    for (int c = 0; c < 30 && k < 5; c++) begin
      bus.M_READY = (c % 3 == 2);
      set_src(1, 1'b1, vdata(60, k), (k == 4) ? 6'd3 : 6'd0, k == 4, 1'b0);
      #1;
      chk_vec("bp_grant", 64'(grant), 64'(4'b0010));
      chk_bit("bp_mvalid", bus.M_VALID, 1'b1);
      chk_vec("bp_mdata", bus.M_DATA, vdata(60, k));
      chk_bit("bp_mlast", bus.M_LAST, k == 4);
      chk_vec("bp_sready", 64'(bus.S_READY), bus.M_READY ? 64'(4'b0010) : 64'(0));
      if (bus.M_READY) k++;
      tick();
    end
    chk_vec("bp_beats", 64'(k), 64'(5));
    clear_srcs();
    bus.M_READY = 1'b1;
    idle_chk("bp_end");

    // ---------------- source abort on beat 2 of 4 (rr = 2) ----------------
    set_src(1, 1'b1, vdata(70, 0), '0, 1'b0, 1'b0);
    idle_chk("ab_req");
    tick();
    pass_beat("ab_b0", 1, vdata(70, 0), '0, 1'b0, 1'b0);
    pass_beat("ab_b1", 1, vdata(70, 1), '0, 1'b0, 1'b1);
    clear_srcs();
    set_src(0, 1'b1, vdata(71, 0), '0, 1'b1, 1'b0);
    set_src(2, 1'b1, vdata(71, 2), '0, 1'b1, 1'b0);
    idle_chk("ab_idle");
    tick();
    pass_beat("ab_next2", 2, vdata(71, 2), '0, 1'b1, 1'b0);
    set_src(2, 1'b0, '0, '0, 1'b0, 1'b0);
    idle_chk("ab_idle2");
    tick();
    pass_beat("ab_next0", 0, vdata(71, 0), '0, 1'b1, 1'b0);
    clear_srcs();

    // ---------------- disable source 3 mid-packet (rr = 1) ----------------
    set_src(3, 1'b1, vdata(80, 0), '0, 1'b0, 1'b0);
    idle_chk("dis_req");
    tick();
    pass_beat("dis_b0", 3, vdata(80, 0), '0, 1'b0, 1'b0);
    pass_beat("dis_b1", 3, vdata(80, 1), '0, 1'b0, 1'b0);
    set_src(3, 1'b1, vdata(80, 2), '0, 1'b1, 1'b0);
    act[3] = 1'b0;
    #1;
    chk_bit("dis_drop_mvalid", bus.M_VALID, 1'b0);
    chk_bit("dis_drop_sready", bus.S_READY[3], 1'b1);
    chk_vec("dis_drop_grant", 64'(grant), 64'(4'b1000));
    tick();
    bus.M_READY = 1'b0;
    for (int c = 0; c < 2; c++) begin
      #1;
      chk_bit("flush_mvalid", bus.M_VALID, 1'b1);
      chk_bit("flush_mabort", bus.M_ABORT, 1'b1);
      chk_bit("flush_mlast", bus.M_LAST, 1'b0);
      chk_vec("flush_mbytes", 64'(bus.M_BYTES), 64'(0));
      chk_bit("flush_sready", bus.S_READY[3], 1'b1);
      chk_vec("flush_grant", 64'(grant), 64'(4'b1000));
      if (c == 1) bus.M_READY = 1'b1;
      tick();
    end
    idle_chk("flush_done");
    chk_bit("drain_sready", bus.S_READY[3], 1'b1);
    tick();
    idle_chk("drain_idle");
    clear_srcs();
    act = '1;

    // ---------------- disable source 0 before its first beat (rr = 0) ----------------
    bus.M_READY = 1'b0;
    set_src(0, 1'b1, vdata(90, 0), '0, 1'b1, 1'b0);
    set_src(2, 1'b1, vdata(90, 2), '0, 1'b1, 1'b0);
    idle_chk("pre_req");
    tick();
    #1;
    chk_vec("pre_grant0", 64'(grant), 64'(4'b0001));
    chk_bit("pre_mvalid", bus.M_VALID, 1'b1);
    chk_bit("pre_sready_stall", bus.S_READY[0], 1'b0);
    tick();
    act[0] = 1'b0;
    #1;
    chk_bit("pre_dis_mvalid", bus.M_VALID, 1'b0);
    chk_bit("pre_dis_sready", bus.S_READY[0], 1'b1);
    tick();
    idle_chk("pre_noabort");
    bus.M_READY = 1'b1;
    tick();
    #1;
    chk_vec("pre_grant2", 64'(grant), 64'(4'b0100));
    chk_vec("pre_mdata", bus.M_DATA, vdata(90, 2));
    tick();
    clear_srcs();
    act = '1;

    // ---------------- reset on beat 2 of a packet (rr = 3) ----------------
    set_src(1, 1'b1, vdata(95, 0), '0, 1'b0, 1'b0);
    idle_chk("rstp_req");
    tick();
    pass_beat("rstp_b0", 1, vdata(95, 0), '0, 1'b0, 1'b0);
    set_src(1, 1'b1, vdata(95, 1), '0, 1'b0, 1'b0);
    rst = 1'b1;
    tick();
    idle_chk("rstp_after");
    chk_vec("rstp_mdata", bus.M_DATA, 64'(0));
    rst = 1'b0;
    clear_srcs();
    tick();
    idle_chk("rstp_idle");

    // ---------------- randomized traffic vs behavioural model ----------------
    rst = 1'b1;
    tick();
    rst = 1'b0;
    owner = -1; nacc = 0; rr_m = 0; flushing = 0;
    for (int s = 0; s < NIN; s++) rem[s] = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      for (int s = 0; s < NIN; s++) if ($urandom_range(0, 49) == 0) act[s] = ~act[s];
      bus.M_READY = ($urandom_range(0, 9) < 7);
      for (int s = 0; s < NIN; s++)
        if (!bus.S_VALID[s] && $urandom_range(0, 1) == 1) new_beat(s);

      e_sready = ~act;
      e_grant  = (owner < 0) ? '0 : NIN'(1) << owner;
      e_mvalid = 1'b0; e_data = '0; e_bytes = '0; e_last = 1'b0; e_abort = 1'b0;
      if (owner >= 0) begin
        if (flushing) begin
          e_mvalid = 1'b1;
          e_abort  = 1'b1;
        end else if (act[owner]) begin
          e_mvalid = bus.S_VALID[owner];
          e_data   = bus.S_DATA[owner*DW +: DW];
          e_bytes  = bus.S_BYTES[owner*BW +: BW];
          e_last   = bus.S_LAST[owner];
          e_abort  = bus.S_ABORT[owner];
          e_sready[owner] = bus.M_READY;
        end
      end
      #1;
      chk_vec("rnd_grant", 64'(grant), 64'(e_grant));
      chk_bit("rnd_mvalid", bus.M_VALID, e_mvalid);
      chk_vec("rnd_sready", 64'(bus.S_READY), 64'(e_sready));
      if (e_mvalid) begin
        if (!flushing) chk_vec("rnd_mdata", bus.M_DATA, e_data);
        chk_vec("rnd_mbytes", 64'(bus.M_BYTES), 64'(e_bytes));
        chk_bit("rnd_mlast", bus.M_LAST, e_last);
        chk_bit("rnd_mabort", bus.M_ABORT, e_abort);
      end

      if (owner < 0) begin
        found = 0;
        for (int i = 0; i < NIN; i++) begin
          g = (rr_m + i) % NIN;
          if (!found && bus.S_VALID[g] && act[g]) begin
            found = 1; owner = g; nacc = 0;
          end
        end
      end else if (flushing) begin
        if (bus.M_READY) begin
          rr_m = (owner + 1) % NIN; owner = -1; flushing = 0;
        end
      end else if (!act[owner]) begin
        if (nacc > 0) flushing = 1;
        else begin rr_m = (owner + 1) % NIN; owner = -1; end
      end else if (bus.S_VALID[owner] && bus.M_READY) begin
        nacc++;
        if (bus.S_LAST[owner] || bus.S_ABORT[owner]) begin
          rr_m = (owner + 1) % NIN; owner = -1;
        end
      end

      acc = bus.S_VALID & e_sready;
      tick();
      for (int s = 0; s < NIN; s++) begin
        if (acc[s]) begin
          if (bus.S_LAST[s] || bus.S_ABORT[s]) rem[s] = 0;
          else if (rem[s] > 0) rem[s]--;
          bus.S_VALID[s] = 1'b0;
        end
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
